// File: rtl/calc_arbiter_if.sv
// Requester-side and calculator-side signals of the shared-calculator arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface calc_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_a;
    logic [16*NUM_REQ-1:0] req_b;
    logic [2*NUM_REQ-1:0]  req_op;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [NUM_REQ-1:0]    resp_ready;
    logic [15:0]           resp_result;
    logic                  resp_error;
    logic [15:0]           calc_a;
    logic [15:0]           calc_b;
    logic                  calc_add;
    logic                  calc_subtract;
    logic                  calc_divide;
    logic                  calc_multiply;
    logic [15:0]           calc_result;
    logic                  calc_invalid_input;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, resp_ready, calc_result, calc_invalid_input,
        output req_ready, resp_valid, resp_result, resp_error, calc_a, calc_b,
               calc_add, calc_subtract, calc_divide, calc_multiply, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, resp_ready, calc_result, calc_invalid_input,
        input  req_ready, resp_valid, resp_result, resp_error, calc_a, calc_b,
               calc_add, calc_subtract, calc_divide, calc_multiply, busy
    );
endinterface

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one 16-bit calculator among NUM_REQ requesters:
// grant, hold operands for CALC_LATENCY cycles, capture result, return it to the winner.
module calc_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CALC_LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    calc_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (CALC_LATENCY >= 1) ? $clog2(CALC_LATENCY + 1) : 1;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_DIV = 2'd2;
    localparam logic [1:0] OP_MUL = 2'd3;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || CALC_LATENCY < 1) begin : g_bad_param
            $error("calc_arbiter: NUM_REQ must be 2..8 and CALC_LATENCY >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
    } calc_req_t;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    calc_req_t        req_q, req_d;
    logic             dz_q, dz_d;
    logic [15:0]      res_q, res_d;
    logic             err_q, err_d;
    logic             busy_q;

    logic             found;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            gnt_q  <= '0;
            cnt_q  <= '0;
            req_q  <= '0;
            dz_q   <= 1'b0;
            res_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
            cnt_q  <= cnt_d;
            req_q  <= req_d;
            dz_q   <= dz_d;
            res_q  <= res_d;
            err_q  <= err_d;
            busy_q <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        dz_d    = dz_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = gnt_idx;
                    ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                    req_d.a  = bus.req_a[16*gnt_idx +: 16];
                    req_d.b  = bus.req_b[16*gnt_idx +: 16];
                    req_d.op = bus.req_op[2*gnt_idx +: 2];
                    dz_d    = (req_d.op == OP_DIV) && (req_d.b == 16'd0);
                    cnt_d   = CNT_W'(CALC_LATENCY);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == CNT_W'(1)) begin
                    // Divide by zero never reaches the calculator; its error is known up front.
                    res_d   = dz_q ? 16'd0 : bus.calc_result;
                    err_d   = dz_q | bus.calc_invalid_input;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (bus.resp_ready[gnt_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready     = '0;
        bus.resp_valid    = '0;
        bus.calc_a        = '0;
        bus.calc_b        = '0;
        bus.calc_add      = 1'b0;
        bus.calc_subtract = 1'b0;
        bus.calc_divide   = 1'b0;
        bus.calc_multiply = 1'b0;
        bus.resp_result   = res_q;
        bus.resp_error    = err_q;
        bus.busy          = busy_q;
        // Grant strobe is combinational and suppressed while reset is held.
        if (state_q == IDLE && found && rst_n) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
        if (state_q == RESP) begin
            bus.resp_valid[gnt_q] = 1'b1;
        end
        if (state_q == EXEC) begin
            bus.calc_a = req_q.a;
            bus.calc_b = req_q.b;
            if (!dz_q) begin
                bus.calc_add      = (req_q.op == OP_ADD);
                bus.calc_subtract = (req_q.op == OP_SUB);
                bus.calc_divide   = (req_q.op == OP_DIV);
                bus.calc_multiply = (req_q.op == OP_MUL);
            end
        end
    end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with NUM_REQ=4, CALC_LATENCY=2 and a behavioural
// 16-bit calculator stub whose invalid flag can be forced.
module tb_calc_arbiter;

    localparam int unsigned NR  = 4;
    localparam int unsigned LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    calc_arbiter_if #(.NUM_REQ(NR)) bus ();

    calc_arbiter #(.NUM_REQ(NR), .CALC_LATENCY(LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   checks = 0;
    int   errors = 0;
    logic force_inv = 1'b0;
    logic [3:0] str;

    // {add, subtract, divide, multiply}
    assign str = {bus.calc_add, bus.calc_subtract, bus.calc_divide, bus.calc_multiply};

    always_comb begin
        bus.calc_result = 16'h0000;
        if (bus.calc_add)           bus.calc_result = bus.calc_a + bus.calc_b;
        else if (bus.calc_subtract) bus.calc_result = bus.calc_a - bus.calc_b;
        else if (bus.calc_multiply) bus.calc_result = bus.calc_a * bus.calc_b;
        else if (bus.calc_divide)   bus.calc_result = (bus.calc_b != 16'd0) ? bus.calc_a / bus.calc_b : 16'd0;
        bus.calc_invalid_input = force_inv;
    end

    task automatic set_req(input int idx, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        bus.req_a[16*idx +: 16] = a;
        bus.req_b[16*idx +: 16] = b;
        bus.req_op[2*idx +: 2]  = op;
    endtask

    task automatic test_reset();
        bus.req_valid  = 4'hF;
        bus.resp_ready = 4'h0;
        bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        @(negedge clk); #1;
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
        checks++; if (bus.resp_valid !== 4'h0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0000", bus.resp_valid); end
        checks++; if (str !== 4'h0) begin errors++; $display("FAIL reset_strobes got %b exp 0000", str); end
        checks++; if ({bus.calc_a, bus.calc_b} !== 32'h0) begin errors++; $display("FAIL reset_operands got %h exp 0", {bus.calc_a, bus.calc_b}); end
        checks++; if ({bus.busy, bus.resp_error, bus.resp_result} !== 18'h0) begin errors++; $display("FAIL reset_status got %h exp 0", {bus.busy, bus.resp_error, bus.resp_result}); end
        @(negedge clk);
        bus.req_valid = 4'h0;
        rst_n = 1'b1;
    endtask

    // Single add from r0 with full cycle-by-cycle timing.
    task automatic test_single();
        @(negedge clk);
        set_req(0, 16'd7, 16'd5, 2'd0);
        bus.req_valid  = 4'b0001;
        bus.resp_ready = 4'hF;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", bus.req_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle got %b exp 0", bus.busy); end
        for (int k = 1; k <= int'(LAT); k++) begin
            @(negedge clk);
            bus.req_valid = 4'b0000;
            #1;
            checks++; if (str !== 4'b1000) begin errors++; $display("FAIL single_strobe_c%0d got %b exp 1000", k, str); end
            checks++; if ({bus.calc_a, bus.calc_b} !== {16'd7, 16'd5}) begin errors++; $display("FAIL single_operands got %h exp 00070005", {bus.calc_a, bus.calc_b}); end
            checks++; if ({bus.busy, bus.req_ready, bus.resp_valid} !== 9'b1_0000_0000) begin errors++; $display("FAIL single_exec_flags got %b exp 100000000", {bus.busy, bus.req_ready, bus.resp_valid}); end
        end
        @(negedge clk); #1;
        checks++; if (bus.resp_valid !== 4'b0001) begin errors++; $display("FAIL single_resp_valid got %b exp 0001", bus.resp_valid); end
        checks++; if ({bus.resp_error, bus.resp_result} !== {1'b0, 16'd12}) begin errors++; $display("FAIL single_result got err %b res %h exp err 0 res 000c", bus.resp_error, bus.resp_result); end
        checks++; if (str !== 4'h0) begin errors++; $display("FAIL single_strobe_resp got %b exp 0000", str); end
        @(negedge clk); #1;
        checks++; if ({bus.busy, bus.resp_valid} !== 5'b0) begin errors++; $display("FAIL single_back_idle got %b exp 00000", {bus.busy, bus.resp_valid}); end
    endtask

    typedef struct {
        int          idx;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        inv;
        logic [15:0] res;
        logic        err;
        logic [3:0]  stb;
    } tv_t;

    // Each operation, divide by zero, forced invalid flag, wrapping add.
    task automatic test_ops();
        tv_t tv [6];
        tv[0] = '{1, 16'd3,     16'd5,   2'd1, 1'b0, 16'hFFFE, 1'b0, 4'b0100};
        tv[1] = '{2, 16'd300,   16'd300, 2'd3, 1'b0, 16'h5F90, 1'b0, 4'b0001};
        tv[2] = '{3, 16'd100,   16'd7,   2'd2, 1'b0, 16'd14,   1'b0, 4'b0010};
        tv[3] = '{2, 16'd10,    16'd0,   2'd2, 1'b0, 16'd0,    1'b1, 4'b0000};
        tv[4] = '{0, 16'd1,     16'd2,   2'd0, 1'b1, 16'd3,    1'b1, 4'b1000};
        tv[5] = '{1, 16'hFFFF,  16'd2,   2'd0, 1'b0, 16'd1,    1'b0, 4'b1000};
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            set_req(tv[t].idx, tv[t].a, tv[t].b, tv[t].op);
            force_inv      = tv[t].inv;
            bus.req_valid  = 4'(1 << tv[t].idx);
            bus.resp_ready = 4'hF;
            #1;
            checks++; if (bus.req_ready !== 4'(1 << tv[t].idx)) begin errors++; $display("FAIL ops%0d_grant got %b exp %b", t, bus.req_ready, 4'(1 << tv[t].idx)); end
            for (int k = 1; k <= int'(LAT); k++) begin
                @(negedge clk);
                bus.req_valid = 4'h0;
                #1;
                checks++; if (str !== tv[t].stb) begin errors++; $display("FAIL ops%0d_strobe_c%0d got %b exp %b", t, k, str, tv[t].stb); end
            end
            @(negedge clk); #1;
            checks++; if (bus.resp_valid !== 4'(1 << tv[t].idx)) begin errors++; $display("FAIL ops%0d_resp_valid got %b exp %b", t, bus.resp_valid, 4'(1 << tv[t].idx)); end
            checks++; if ({bus.resp_error, bus.resp_result} !== {tv[t].err, tv[t].res}) begin errors++; $display("FAIL ops%0d_result got err %b res %h exp err %b res %h", t, bus.resp_error, bus.resp_result, tv[t].err, tv[t].res); end
            @(negedge clk); #1;
            force_inv = 1'b0;
            checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ops%0d_idle got busy %b exp 0", t, bus.busy); end
        end
    endtask

    // Response withheld: outputs frozen, no new grants, other resp_ready bits ignored.
    task automatic test_stall();
        bit seen;
        @(negedge clk);
        set_req(1, 16'd50, 16'd6, 2'd3);
        bus.req_valid  = 4'b0010;
        bus.resp_ready = 4'b1101;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL stall_grant got %b exp 0010", bus.req_ready); end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            bus.req_valid = 4'hF;
            #1;
            if (bus.resp_valid !== 4'h0) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL stall_resp_timeout got no resp_valid exp resp within 10 cycles"); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            checks++; if (bus.resp_valid !== 4'b0010) begin errors++; $display("FAIL stall_resp_valid_c%0d got %b exp 0010", c, bus.resp_valid); end
            checks++; if ({bus.resp_error, bus.resp_result} !== {1'b0, 16'h012C}) begin errors++; $display("FAIL stall_result_c%0d got err %b res %h exp err 0 res 012c", c, bus.resp_error, bus.resp_result); end
            checks++; if ({bus.req_ready, str} !== 8'h00) begin errors++; $display("FAIL stall_quiet_c%0d got %b exp 00000000", c, {bus.req_ready, str}); end
        end
        @(negedge clk);
        bus.req_valid  = 4'h0;
        bus.resp_ready = 4'b0010;
        #1;
        checks++; if (bus.resp_valid !== 4'b0010) begin errors++; $display("FAIL stall_release_hold got %b exp 0010", bus.resp_valid); end
        @(negedge clk); #1;
        checks++; if ({bus.busy, bus.resp_valid} !== 5'b0) begin errors++; $display("FAIL stall_release_idle got %b exp 00000", {bus.busy, bus.resp_valid}); end
        bus.resp_ready = 4'hF;
    endtask

    // Reset in the middle of EXEC drops the transaction and rewinds the pointer.
    task automatic test_reset_mid_exec();
        @(negedge clk);
        set_req(3, 16'd9, 16'd9, 2'd0);
        bus.req_valid = 4'b1000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rstmid_grant got %b exp 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'hF;
        #1;
        checks++; if (str !== 4'b1000) begin errors++; $display("FAIL rstmid_exec_strobe got %b exp 1000", str); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.req_ready, bus.resp_valid, str} !== 12'h0) begin errors++; $display("FAIL rstmid_handshake got %b exp 0", {bus.req_ready, bus.resp_valid, str}); end
        checks++; if ({bus.calc_a, bus.calc_b} !== 32'h0) begin errors++; $display("FAIL rstmid_operands got %h exp 0", {bus.calc_a, bus.calc_b}); end
        checks++; if ({bus.busy, bus.resp_error, bus.resp_result} !== 18'h0) begin errors++; $display("FAIL rstmid_status got %h exp 0", {bus.busy, bus.resp_error, bus.resp_result}); end
        @(negedge clk); #1;
        checks++; if (bus.req_ready !== 4'h0) begin errors++; $display("FAIL rstmid_held_ready got %b exp 0000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'h0;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            checks++; if ({bus.busy, bus.resp_valid} !== 5'b0) begin errors++; $display("FAIL rstmid_no_resp_c%0d got %b exp 00000", c, {bus.busy, bus.resp_valid}); end
        end
    endtask

    // All requesters valid: round-robin 0,1,2,3,0 at one issue every LAT+2 cycles.
    task automatic test_back_to_back();
        int order [5] = '{0, 1, 2, 3, 0};
        int ngrant = 0;
        int nresp  = 0;
        int last   = 0;
        for (int i = 0; i < 4; i++) set_req(i, 16'(10 * (i + 1)), 16'd3, 2'd0);
        bus.resp_ready = 4'hF;
        for (int c = 0; c < 5 * int'(LAT + 2); c++) begin
            @(negedge clk);
            bus.req_valid = (ngrant == 5) ? 4'h0 : 4'hF;
            #1;
            checks++; if ($countones(bus.req_ready) > 1) begin errors++; $display("FAIL b2b_onehot_c%0d got %b exp at most one bit", c, bus.req_ready); end
            if (bus.req_ready !== 4'h0) begin
                checks++;
                if (ngrant >= 5) begin errors++; $display("FAIL b2b_extra_grant_c%0d got %b exp 0000", c, bus.req_ready); end
                else if (bus.req_ready !== 4'(1 << order[ngrant])) begin errors++; $display("FAIL b2b_grant%0d got %b exp %b", ngrant, bus.req_ready, 4'(1 << order[ngrant])); end
                if (ngrant > 0) begin
                    checks++; if (c - last !== int'(LAT + 2)) begin errors++; $display("FAIL b2b_interval%0d got %0d exp %0d", ngrant, c - last, LAT + 2); end
                end
                last = c;
                ngrant++;
            end else begin
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_c%0d got %b exp 1", c, bus.busy); end
            end
            if (bus.resp_valid !== 4'h0 && nresp < 5) begin
                checks++; if (bus.resp_valid !== 4'(1 << order[nresp])) begin errors++; $display("FAIL b2b_resp%0d_valid got %b exp %b", nresp, bus.resp_valid, 4'(1 << order[nresp])); end
                checks++; if (bus.resp_result !== 16'(10 * (order[nresp] + 1) + 3)) begin errors++; $display("FAIL b2b_resp%0d_result got %h exp %h", nresp, bus.resp_result, 16'(10 * (order[nresp] + 1) + 3)); end
                nresp++;
            end
        end
        checks++; if (ngrant !== 5 || nresp !== 5) begin errors++; $display("FAIL b2b_counts got grants %0d resps %0d exp 5 5", ngrant, nresp); end
        @(negedge clk); #1;
        checks++; if ({bus.busy, bus.resp_valid} !== 5'b0) begin errors++; $display("FAIL b2b_final_idle got %b exp 00000", {bus.busy, bus.resp_valid}); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ops();
        test_stall();
        test_reset_mid_exec();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
